// File: rtl/jbi_ssi_arb.sv
// Round-robin arbiter between the UCB path (req0) and boot/diag prefetch (req1)
// for the single SIF command port; runs one transaction at a time to completion.
module jbi_ssi_arb #(
    parameter int ADDR_W = 28,
    parameter int SZ_W   = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              arst_i,
    // Handshakes: reqN_vld_i is a level held until the one-cycle reqN_gnt_o;
    // SIF completion/timeout are levels held until the matching one-cycle accept.
    input  logic              req0_vld_i,
    input  logic              req0_rw_i,
    input  logic [SZ_W-1:0]   req0_size_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    input  logic              req1_vld_i,
    input  logic              req1_rw_i,
    input  logic [SZ_W-1:0]   req1_size_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    output logic              req0_gnt_o,
    output logic              req0_done_o,
    output logic              req0_tout_o,
    output logic              req1_gnt_o,
    output logic              req1_done_o,
    output logic              req1_tout_o,
    output logic [DATA_W-1:0] arb_rdata_o,
    output logic              arb_tout_rw_o,
    output logic              arb_sif_vld_o,
    output logic              arb_sif_rw_o,
    output logic [SZ_W-1:0]   arb_sif_size_o,
    output logic [ADDR_W-1:0] arb_sif_addr_o,
    output logic [DATA_W-1:0] arb_sif_wdata_o,
    output logic              arb_sif_rdata_accpt_o,
    output logic              arb_sif_timeout_accpt_o,
    input  logic              sif_arb_busy_i,
    input  logic              sif_arb_rdata_vld_i,
    input  logic [DATA_W-1:0] sif_arb_rdata_i,
    input  logic              sif_arb_timeout_i,
    input  logic              sif_arb_timeout_rw_i,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} state_t;

    state_t              state_q, state_d;
    logic                last_owner_q, last_owner_d;
    logic                rw_q, rw_d;
    logic [SZ_W-1:0]     size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                tout_rw_q, tout_rw_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic                tout0_q, tout0_d, tout1_q, tout1_d;
    logic                sif_vld_q, sif_vld_d;
    logic                acc_rd_q, acc_rd_d, acc_to_q, acc_to_d;
    logic                pick1;
    logic                sif_event;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        rw_d         = rw_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        tout_rw_d    = tout_rw_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        tout0_d      = 1'b0;
        tout1_d      = 1'b0;
        sif_vld_d    = 1'b0;
        acc_rd_d     = 1'b0;
        acc_to_d     = 1'b0;
        pick1        = req1_vld_i && (!req0_vld_i || !last_owner_q);
        sif_event    = sif_arb_rdata_vld_i || sif_arb_timeout_i;

        case (state_q)
            // The edge leaving ACK is already an arbitration point, so a waiting
            // requester is captured back-to-back without an extra IDLE cycle.
            ST_IDLE, ST_ACK: begin
                state_d = ST_IDLE;
                if ((req0_vld_i || req1_vld_i) && !sif_arb_busy_i) begin
                    state_d      = ST_ISSUE;
                    last_owner_d = pick1;
                    sif_vld_d    = 1'b1;
                    gnt0_d       = !pick1;
                    gnt1_d       = pick1;
                    rw_d         = pick1 ? req1_rw_i    : req0_rw_i;
                    size_d       = pick1 ? req1_size_i  : req0_size_i;
                    addr_d       = pick1 ? req1_addr_i  : req0_addr_i;
                    wdata_d      = pick1 ? req1_wdata_i : req0_wdata_i;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (sif_event) begin
                    state_d   = ST_ACK;
                    rdata_d   = sif_arb_rdata_i;
                    tout_rw_d = sif_arb_timeout_rw_i;
                    acc_rd_d  = sif_arb_rdata_vld_i;
                    acc_to_d  = sif_arb_timeout_i;
                    // Completion wins over a simultaneous timeout.
                    done0_d   = sif_arb_rdata_vld_i && !last_owner_q;
                    done1_d   = sif_arb_rdata_vld_i && last_owner_q;
                    tout0_d   = !sif_arb_rdata_vld_i && !last_owner_q;
                    tout1_d   = !sif_arb_rdata_vld_i && last_owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            rw_q         <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            tout_rw_q    <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            tout0_q      <= 1'b0;
            tout1_q      <= 1'b0;
            sif_vld_q    <= 1'b0;
            acc_rd_q     <= 1'b0;
            acc_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            rw_q         <= rw_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            tout_rw_q    <= tout_rw_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            tout0_q      <= tout0_d;
            tout1_q      <= tout1_d;
            sif_vld_q    <= sif_vld_d;
            acc_rd_q     <= acc_rd_d;
            acc_to_q     <= acc_to_d;
        end
    end

    assign req0_gnt_o              = gnt0_q;
    assign req1_gnt_o              = gnt1_q;
    assign req0_done_o             = done0_q;
    assign req1_done_o             = done1_q;
    assign req0_tout_o             = tout0_q;
    assign req1_tout_o             = tout1_q;
    assign arb_rdata_o             = rdata_q;
    assign arb_tout_rw_o           = tout_rw_q;
    assign arb_sif_vld_o           = sif_vld_q;
    assign arb_sif_rw_o            = rw_q;
    assign arb_sif_size_o          = size_q;
    assign arb_sif_addr_o          = addr_q;
    assign arb_sif_wdata_o         = wdata_q;
    assign arb_sif_rdata_accpt_o   = acc_rd_q;
    assign arb_sif_timeout_accpt_o = acc_to_q;
    assign dbg_state_o             = state_q;

endmodule

// File: doc/jbi_ssi_arb.md
# jbi_ssi_arb

Two-requester arbiter and transaction sequencer for the SSI serial interface (SIF) engine in the JBI ROM interface block. It shares the single SIF command port between requester 0 (UCB path) and requester 1 (boot/diagnostic prefetch). It launches one transaction at a time, waits for completion or timeout, and returns data and status to the owning requester. It sits between the requesters and the SIF engine and replaces the direct request-to-SIF connection.

## Interface
Parameters:
- ADDR_W, 28, SIF address width.
- SZ_W, 2, SIF size-code width.
- DATA_W, 64, read/write data width.

Ports (N = 0, 1; each reqN_* port exists once per requester):
- clk  in  1  JBus clock; all state is on the rising edge.
- arst  in  1  Asynchronous, active-high reset.
- reqN_vld  in  1  Requester N has a command pending; level; held until reqN_gnt.
- reqN_rw  in  1  1 = read, 0 = write.
- reqN_size  in  SZ_W  Size code.
- reqN_addr  in  ADDR_W  Address.
- reqN_wdata  in  DATA_W  Write data.
- reqN_gnt  out  1  One-cycle pulse: command captured and launched.
- reqN_done  out  1  One-cycle pulse: transaction completed; arb_rdata valid in the same cycle.
- reqN_tout  out  1  One-cycle pulse: transaction timed out.
- arb_rdata  out  DATA_W  Read data, registered; valid with reqN_done.
- arb_tout_rw  out  1  rw of the timed-out transaction; valid with reqN_tout.
- arb_sif_vld  out  1  One-cycle command strobe to SIF.
- arb_sif_rw / arb_sif_size / arb_sif_addr / arb_sif_wdata  out  1 / SZ_W / ADDR_W / DATA_W  Registered command fields; held stable from the strobe until return to IDLE.
- arb_sif_rdata_accpt  out  1  One-cycle accept of SIF completion.
- arb_sif_timeout_accpt  out  1  One-cycle accept of SIF timeout.
- sif_arb_busy  in  1  SIF cannot take a command.
- sif_arb_rdata_vld  in  1  Completion (read data, or write ack); held until accepted.
- sif_arb_rdata  in  DATA_W  Read data.
- sif_arb_timeout  in  1  Timeout; held until accepted.
- sif_arb_timeout_rw  in  1  rw of the timed-out command.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any reqN_vld and !sif_arb_busy, pick the winner, capture its fields into the command registers, record it as owner, and go to ISSUE. Otherwise stay in IDLE.
- Winner selection:
  - Only one requester valid: that requester wins.
  - Both valid: the requester that is not last_owner wins (round-robin).
  - last_owner updates on every capture.
- ISSUE: assert arb_sif_vld and reqN_gnt of the owner for exactly one cycle, then go to WAIT.
- WAIT: stay until sif_arb_rdata_vld or sif_arb_timeout. On exit, latch sif_arb_rdata into arb_rdata and sif_arb_timeout_rw into arb_tout_rw, latch which event(s) occurred, and go to ACK.
- ACK, one cycle:
  - Pulse the accept output for each latched event.
  - Pulse the owner's reqN_done if completion was latched, otherwise reqN_tout.
  - Go to IDLE.
- Completion and timeout in the same WAIT cycle: assert both accepts in ACK, pulse only reqN_done, leave reqN_tout low.
- Requester behaviour:
  - A requester may drop reqN_vld before its gnt (withdraw). The arbiter ignores it from the next IDLE evaluation on.
  - Fields sampled at capture are authoritative. Later changes to reqN_* have no effect on the in-flight command.
- sif_arb_busy is sampled only in IDLE.
- Non-owner done/tout/gnt outputs are never asserted.

## Timing
- Reset (arst high, asynchronous):
  - FSM goes to IDLE; last_owner = 1, so requester 0 wins the first contention.
  - All outputs 0: gnt, done, tout, arb_sif_vld, accepts, command registers, arb_rdata, arb_tout_rw.
  - Deassertion is synchronous to clk.
- Reset during WAIT or ACK abandons the transaction. No done/tout is issued afterwards.
- reqN_vld sampled at edge E in IDLE leads to gnt and arb_sif_vld in the cycle after E (registered, 1-cycle latency).
- sif_arb_rdata_vld seen at edge F in WAIT leads to accept and done in the cycle after F.
- Next command capture is possible at the edge ending ACK. Its strobe follows one cycle later.
- Minimum spacing between two arb_sif_vld strobes is 3 cycles plus SIF wait time.
- Every arbiter output is registered; no combinational path from input to output.

## Test plan
- Single read: req0 read, addr=0x0000100, sif returns rdata 0x0123456789ABCDEF after 5 cycles. Expect: req0_gnt one cycle after vld, arb_sif_addr=0x0000100, rw=1; then one-cycle arb_sif_rdata_accpt together with req0_done, arb_rdata=0x0123456789ABCDEF.
- Contention and fairness: req0 and req1 held valid continuously across 4 transactions. Expect grant order 0,1,0,1 and never two commands outstanding.
- Busy hold-off: sif_arb_busy=1 for 10 cycles while req1 is valid. Expect no arb_sif_vld and no gnt until the cycle after busy drops.
- Timeout: req1 write, sif_arb_timeout=1 with timeout_rw=0. Expect arb_sif_timeout_accpt and req1_tout pulses, arb_tout_rw=0, no req1_done.
- Simultaneous completion and timeout: both asserted in the same WAIT cycle. Expect both accepts asserted, req0_done=1, req0_tout=0.
- Async reset mid-WAIT: assert arst. Expect all outputs 0 immediately; after release, a queued req1 is granted before a simultaneous req0 only if req0 was not valid, since req0 wins the first contention.
